jogo_sequencia_param: RTL and testbench

//  Parametrised sequence-memory game core (successor to the 4-button, 2-level game top).

---
 rtl/jogo_sequencia_pkg.sv | 32 +++
 rtl/jogo_detector_jogada.sv | 38 +++
 rtl/jogo_sequencia_param.sv | 201 ++++++++++++++++++++
 tb/tb_jogo_sequencia_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_sequencia_pkg.sv
// Shared definitions for the sequence-memory game: state codes, LFSR constants,
// round-count and per-press time-limit helpers.
package jogo_sequencia_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        NOVO_ELEM   = 4'h2,
        MOSTRA      = 4'h3,
        APAGADO     = 4'h4,
        ESPERA      = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        PROX_RODADA = 4'h8,
        FIM_GANHOU  = 4'hA,
        FIM_PERDEU  = 4'hB,
        FIM_TIMEOUT = 4'hC
    } estado_t;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int rodadas(input logic [1:0] nivel, input int prof);
        return (int'(nivel) + 1) * prof / 4;
    endfunction

    function automatic int limite_tempo(input logic nivel_tempo, input int t_jogada);
        return nivel_tempo ? t_jogada / 2 : t_jogada;
    endfunction

endpackage

// File: rtl/jogo_detector_jogada.sv
// Player press detector: rising edge of "any button", lowest-set-bit code and
// a valid flag that is low when more than one button is down.
module jogo_detector_jogada #(
    parameter int N_BOTOES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    output logic                jogada,
    output logic [3:0]          codigo,
    output logic                valido
);

    logic anterior;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anterior <= 1'b0;
        end else begin
            anterior <= |botoes;
        end
    end

    // a held button keeps anterior high, so nothing counts until all are released
    assign jogada = (|botoes) & ~anterior;

    always_comb begin
        codigo = 4'd0;
        for (int i = N_BOTOES - 1; i >= 0; i--) begin
            if (botoes[i]) begin
                codigo = 4'(i);
            end
        end
    end

    assign valido = ((botoes & (botoes - N_BOTOES'(1))) == '0);

endmodule

// File: rtl/jogo_sequencia_param.sv
// Parametrised sequence-memory game core: shows a growing sequence on the LEDs, then checks presses.
// Optional feature macro SEQ_ALEATORIA_EN selects LFSR-generated elements instead of i mod N_BOTOES.
module jogo_sequencia_param
    import jogo_sequencia_pkg::*;
#(
    parameter int N_BOTOES  = 4,
    parameter int PROF      = 16,
    parameter int T_LED     = 1000,
    parameter int T_APAGADO = 500,
    parameter int T_JOGADA  = 5000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [N_BOTOES-1:0]     botoes,
    input  logic [1:0]              nivel,
    input  logic                    nivel_tempo,
    output logic [N_BOTOES-1:0]     leds,
    output logic                    vez_jogador,
    output logic                    pronto,
    output logic                    ganhou,
    output logic                    perdeu,
    output logic                    timeout,
    output logic [3:0]              db_estado,
    output logic [$clog2(PROF)-1:0] db_rodada,
    output logic [3:0]              db_jogada
);

    localparam int RW    = $clog2(PROF);
    localparam int CW    = $clog2(N_BOTOES);
    localparam int T_M1  = (T_JOGADA > T_LED) ? T_JOGADA : T_LED;
    localparam int T_MAX = (T_M1 > T_APAGADO) ? T_M1 : T_APAGADO;
    localparam int TW    = $clog2(T_MAX + 1);

    estado_t             estado;
    logic [RW-1:0]       rodada;
    logic [RW-1:0]       addr;
    logic [TW-1:0]       timer;
    logic [1:0]          nivel_reg;
    logic                nivel_tempo_reg;
    logic [N_BOTOES-1:0] leds_reg;
    logic [3:0]          jogada_reg;
    logic                jogada_valida;
    logic [CW-1:0]       mem [PROF];
    logic [CW-1:0]       novo;
    logic [RW-1:0]       ultima;
    logic [TW-1:0]       limite;
    logic                jogada;
    logic [3:0]          codigo;
    logic                valido;

    function automatic logic [N_BOTOES-1:0] um_quente(input logic [CW-1:0] c);
        return N_BOTOES'(1) << c;
    endfunction

`ifdef SEQ_ALEATORIA_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign novo = CW'(32'(lfsr[7:0]) % N_BOTOES);
`else
    assign novo = CW'(32'(rodada) % N_BOTOES);
`endif

    assign ultima = RW'(rodadas(nivel_reg, PROF) - 1);
    assign limite = TW'(limite_tempo(nivel_tempo_reg, T_JOGADA));

    jogo_detector_jogada #(.N_BOTOES(N_BOTOES)) u_detector (
        .clock  (clock),
        .reset  (reset),
        .botoes (botoes),
        .jogada (jogada),
        .codigo (codigo),
        .valido (valido)
    );

    always_ff @(posedge clock) begin
        if (estado == NOVO_ELEM) begin
            mem[rodada] <= novo;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado          <= INICIAL;
            rodada          <= '0;
            addr            <= '0;
            timer           <= '0;
            nivel_reg       <= '0;
            nivel_tempo_reg <= 1'b0;
            leds_reg        <= '0;
            jogada_reg      <= '0;
            jogada_valida   <= 1'b0;
        end else begin
            case (estado)
                INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                    if (iniciar) begin
                        estado <= PREPARACAO;
                    end
                end
                PREPARACAO: begin
                    nivel_reg       <= nivel;
                    nivel_tempo_reg <= nivel_tempo;
                    rodada          <= '0;
                    addr            <= '0;
                    timer           <= '0;
                    leds_reg        <= '0;
                    jogada_reg      <= '0;
                    jogada_valida   <= 1'b0;
                    estado          <= NOVO_ELEM;
                end
                NOVO_ELEM: begin
                    // mem[0] is being written this cycle in round 0, so bypass it
                    addr     <= '0;
                    timer    <= '0;
                    leds_reg <= um_quente((rodada == '0) ? novo : mem[0]);
                    estado   <= MOSTRA;
                end
                MOSTRA: begin
                    if (timer == TW'(T_LED - 1)) begin
                        timer    <= '0;
                        leds_reg <= '0;
                        estado   <= APAGADO;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGADO: begin
                    if (timer == TW'(T_APAGADO - 1)) begin
                        timer <= '0;
                        if (addr == rodada) begin
                            addr   <= '0;
                            estado <= ESPERA;
                        end else begin
                            addr     <= addr + 1'b1;
                            leds_reg <= um_quente(mem[addr + 1'b1]);
                            estado   <= MOSTRA;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ESPERA: begin
                    if (jogada) begin
                        jogada_reg    <= codigo;
                        jogada_valida <= valido;
                        timer         <= '0;
                        estado        <= COMPARA;
                    end else if (timer == limite - 1'b1) begin
                        timer  <= '0;
                        estado <= FIM_TIMEOUT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                COMPARA: begin
                    if (!jogada_valida || jogada_reg != 4'(mem[addr])) begin
                        estado <= FIM_PERDEU;
                    end else if (addr == rodada) begin
                        estado <= PROX_RODADA;
                    end else begin
                        estado <= PROX_JOGADA;
                    end
                end
                PROX_JOGADA: begin
                    addr   <= addr + 1'b1;
                    timer  <= '0;
                    estado <= ESPERA;
                end
                PROX_RODADA: begin
                    if (rodada == ultima) begin
                        estado <= FIM_GANHOU;
                    end else begin
                        rodada <= rodada + 1'b1;
                        estado <= NOVO_ELEM;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    // during the player's turn the LEDs echo the buttons directly
    assign leds        = (estado == ESPERA) ? botoes : leds_reg;
    assign vez_jogador = (estado == ESPERA);
    assign ganhou      = (estado == FIM_GANHOU);
    assign perdeu      = (estado == FIM_PERDEU);
    assign timeout     = (estado == FIM_TIMEOUT);
    assign pronto      = ganhou | perdeu | timeout;
    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_jogada   = jogada_reg;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Bench for jogo_sequencia_param: a scripted game timeline derived from the game rules
// feeds per-cycle expectations to a single compare process, plus literal spot checks.
module tb_jogo_sequencia_param;

    localparam int N_BOTOES  = 4;
    localparam int PROF      = 16;
    localparam int T_LED     = 3;
    localparam int T_APAGADO = 2;
    localparam int T_JOGADA  = 12;

    logic                    clock;
    logic                    reset;
    logic                    iniciar;
    logic [N_BOTOES-1:0]     botoes;
    logic [1:0]              nivel;
    logic                    nivel_tempo;
    logic [N_BOTOES-1:0]     leds;
    logic                    vez_jogador, pronto, ganhou, perdeu, timeout;
    logic [3:0]              db_estado;
    logic [$clog2(PROF)-1:0] db_rodada;
    logic [3:0]              db_jogada;

    jogo_sequencia_param #(
        .N_BOTOES(N_BOTOES), .PROF(PROF), .T_LED(T_LED),
        .T_APAGADO(T_APAGADO), .T_JOGADA(T_JOGADA)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
        .nivel(nivel), .nivel_tempo(nivel_tempo), .leds(leds),
        .vez_jogador(vez_jogador), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado),
        .db_rodada(db_rodada), .db_jogada(db_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int failed = 0;

    // expectation for the current cycle, consumed by the compare process
    logic          exp_chk = 1'b0;
    logic          exp_db;
    logic [3:0]    exp_st;
    logic [3:0]    exp_leds;
    logic [3:0]    exp_rd;
    logic [3:0]    exp_jg;
    logic [20:0]   act_v, exp_v;
    logic          ruido = 1'b0;

    // state the game ends in, with the debug values it must hold there
    logic [3:0]    m_estado = 4'h0;
    logic [3:0]    m_rodada = 4'h0;
    logic [3:0]    m_jogada = 4'h0;

`ifdef SEQ_ALEATORIA_EN
    logic [15:0] m_lfsr;
    always @(posedge clock or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
`endif

    always @(negedge clock) begin
        if (exp_chk) begin
            act_v = {db_estado, leds, vez_jogador, pronto, ganhou, perdeu, timeout,
                     4'(db_rodada), db_jogada};
            exp_v = {exp_st, exp_leds, exp_st == 4'h5,
                     (exp_st == 4'hA) || (exp_st == 4'hB) || (exp_st == 4'hC),
                     exp_st == 4'hA, exp_st == 4'hB, exp_st == 4'hC, exp_rd, exp_jg};
            if (!exp_db) begin
                act_v[7:0] = 8'h0;
                exp_v[7:0] = 8'h0;
            end
            tests++;
            if (act_v !== exp_v) begin
                failed++;
                if (failed <= 20)
                    $display("FAIL cycle_check t=%0t actual=%h required=%h (estado,leds,flags,rodada,jogada)",
                             $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // one clock cycle: drive inputs, publish expectation, advance past the edge
    task automatic cyc(input logic ini, input logic [3:0] b, input logic [3:0] st,
                       input logic [3:0] l, input int rd, input logic [3:0] jg, input logic db);
        iniciar = ini;
        if (ruido) begin
            iniciar     = ($urandom_range(0, 3) == 0);
            nivel       = 2'($urandom_range(0, 3));
            nivel_tempo = 1'($urandom_range(0, 1));
        end
        botoes   = b;
        exp_st   = st;
        exp_leds = l;
        exp_rd   = 4'(rd);
        exp_jg   = jg;
        exp_db   = db;
        exp_chk  = 1'b1;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] menor(input logic [3:0] b);
        logic [3:0] r;
        r = 4'd0;
        for (int i = N_BOTOES - 1; i >= 0; i--) if (b[i]) r = 4'(i);
        return r;
    endfunction

    // fk: 0 play to the end, 1 wrong button, 2 two buttons, 3 no press (timeout) at (fr,fp)
    // hr: round whose first press follows a button held since the display
    task automatic play(input logic [1:0] nv, input logic nt, input int fr, input int fp,
                        input int fk, input int hr);
        int         nr, lim, d;
        logic [3:0] jog, bh, pb, s;
        logic [3:0] seq[$];
        nr  = (int'(nv) + 1) * PROF / 4;
        lim = nt ? T_JOGADA / 2 : T_JOGADA;
        ruido = 1'b0;
        nivel = nv;
        nivel_tempo = nt;
        cyc(1'b1, 4'h0, m_estado, 4'h0, int'(m_rodada), m_jogada, 1'b1);
        cyc(1'b0, 4'h0, 4'h1, 4'h0, 0, 4'h0, 1'b0);
        ruido = 1'b1;
        jog = 4'h0;
        for (int k = 0; k < nr; k++) begin
`ifdef SEQ_ALEATORIA_EN
            s = 4'(int'(m_lfsr[7:0]) % N_BOTOES);
`else
            s = 4'(k % N_BOTOES);
`endif
            chk("elem_range", int'(s), int'(s) % N_BOTOES);
            seq.push_back(s);
            bh = (k == hr) ? (4'h1 << seq[0]) : 4'h0;
            cyc(1'b0, bh, 4'h2, 4'h0, k, jog, 1'b1);
            for (int i = 0; i <= k; i++) begin
                repeat (T_LED) cyc(1'b0, bh, 4'h3, 4'h1 << seq[i], k, jog, 1'b1);
                repeat (T_APAGADO) cyc(1'b0, bh, 4'h4, 4'h0, k, jog, 1'b1);
            end
            for (int j = 0; j <= k; j++) begin
                if (k == fr && j == fp && fk == 3) begin
                    repeat (lim) cyc(1'b0, 4'h0, 4'h5, 4'h0, k, jog, 1'b1);
                    m_estado = 4'hC; m_rodada = 4'(k); m_jogada = jog;
                    ruido = 1'b0; iniciar = 1'b0;
                    return;
                end
                if (k == hr && j == 0) begin
                    d = $urandom_range(1, lim - 2);
                    repeat (d) cyc(1'b0, bh, 4'h5, bh, k, jog, 1'b1);
                    cyc(1'b0, 4'h0, 4'h5, 4'h0, k, jog, 1'b1);
                end else begin
                    d = ($urandom_range(0, 3) == 0) ? lim - 1 : $urandom_range(0, lim - 1);
                    repeat (d) cyc(1'b0, 4'h0, 4'h5, 4'h0, k, jog, 1'b1);
                end
                s = seq[j];
                pb = 4'h1 << s;
                if (k == fr && j == fp && fk == 1) pb = 4'h1 << ((s + 1) % N_BOTOES);
                if (k == fr && j == fp && fk == 2) pb = pb | (4'h1 << ((s + 1) % N_BOTOES));
                cyc(1'b0, pb, 4'h5, pb, k, jog, 1'b1);
                jog = menor(pb);
                cyc(1'b0, 4'h0, 4'h6, 4'h0, k, jog, 1'b1);
                if (k == fr && j == fp && (fk == 1 || fk == 2)) begin
                    m_estado = 4'hB; m_rodada = 4'(k); m_jogada = jog;
                    ruido = 1'b0; iniciar = 1'b0;
                    return;
                end
                cyc(1'b0, 4'h0, (j < k) ? 4'h7 : 4'h8, 4'h0, k, jog, 1'b1);
            end
        end
        m_estado = 4'hA; m_rodada = 4'(nr - 1); m_jogada = jog;
        ruido = 1'b0; iniciar = 1'b0;
    endtask

    initial begin
        #2_000_000;
        failed++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        int nr, fk;
        reset = 1'b1; iniciar = 1'b0; botoes = '0; nivel = '0; nivel_tempo = 1'b0;
        #3;
        chk("reset_outputs", int'({leds, vez_jogador, pronto, ganhou, perdeu, timeout}), 0);
        chk("reset_estado", int'(db_estado), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // first LED after start, then an asynchronous reset in the middle of MOSTRA
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        chk("prep_estado", int'(db_estado), 1);
        @(posedge clock); #1;
        chk("novo_leds_dark", int'(leds), 0);
        @(posedge clock); #1;
        chk("mostra_estado", int'(db_estado), 3);
`ifndef SEQ_ALEATORIA_EN
        chk("mostra_first_led", int'(leds), 1);
`endif
        #2 reset = 1'b1;
        #1;
        chk("async_reset_estado", int'(db_estado), 0);
        chk("async_reset_outputs", int'({leds, vez_jogador, pronto, ganhou, perdeu, timeout}), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_estado = 4'h0; m_rodada = 4'h0; m_jogada = 4'h0;

        // full win at level 0
        play(2'd0, 1'b0, -1, -1, 0, -1);
        chk("win_estado", int'(db_estado), 'hA);
        chk("win_ganhou", int'({ganhou, pronto, perdeu, timeout}), 'b1100);
        chk("win_rodada", int'(db_rodada), 3);

        // wrong button at round 2, second press: 0100 instead of 0010
        play(2'd0, 1'b0, 2, 1, 1, -1);
        chk("loss_estado", int'(db_estado), 'hB);
        chk("loss_perdeu", int'({perdeu, pronto}), 'b11);
`ifndef SEQ_ALEATORIA_EN
        chk("loss_jogada", int'(db_jogada), 2);
`endif

        // no press on the short time level
        play(2'd0, 1'b1, 0, 0, 3, -1);
        chk("timeout_estado", int'(db_estado), 'hC);
        chk("timeout_flag", int'({timeout, pronto}), 'b11);

        // two buttons at once
        play(2'd0, 1'b0, 0, 0, 2, -1);
        chk("dual_estado", int'(db_estado), 'hB);
`ifndef SEQ_ALEATORIA_EN
        chk("dual_jogada", int'(db_jogada), 0);
`endif

        // button held over from the display must not count
        play(2'd0, 1'b0, -1, -1, 0, 1);
        chk("hold_estado", int'(db_estado), 'hA);

        // level 1, short time, win: 8 rounds
        play(2'd1, 1'b1, -1, -1, 0, 3);
        chk("lvl1_rodada", int'(db_rodada), 7);
        chk("lvl1_estado", int'(db_estado), 'hA);

        for (int r = 0; r < 6; r++) begin
            logic [1:0] nv;
            int fr;
            nv = 2'($urandom_range(0, 3));
            nr = (int'(nv) + 1) * PROF / 4;
            fk = $urandom_range(0, 3);
            fr = $urandom_range(0, nr - 1);
            play(nv, 1'($urandom_range(0, 1)), fr, $urandom_range(0, fr), fk,
                 ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, nr - 1));
        end

        exp_chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
